// File: rtl/alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alarm_scheduler
// Purpose  : Shares the buzzer and LED banks between the hourly chime and the
//            user alarm (with snooze/stop). All timing is driven by 1 Hz and
//            8 Hz tick-enable pulses, so the whole block runs on CP alone.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_scheduler #(
  parameter int ALARM_SEC  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int CNT_W      = 12
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       tick1hz,
  input  logic       tick8hz,
  input  logic [4:0] HDATA,
  input  logic [7:0] MDATA,
  input  logic [5:0] HSET,
  input  logic [5:0] MSET,
  input  logic       alarm_en,
  input  logic       chime_en,
  input  logic       snooze,
  input  logic       stop,
  output logic       buzz,
  output logic [3:0] puncshow,
  output logic [3:0] alarmshow,
  output logic       busy,
  output logic [2:0] state_o
);

  localparam int SNZ_W = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

  localparam logic [CNT_W-1:0] c_ALARM_LAST = CNT_W'(ALARM_SEC - 1);
  localparam logic [CNT_W-1:0] c_SNZ_LOAD   = CNT_W'(SNOOZE_MIN * 60);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);
  localparam logic [SNZ_W-1:0] c_MAX_SNZ    = SNZ_W'(MAX_SNOOZE);
  localparam logic [SNZ_W-1:0] c_SNZ_ONE    = SNZ_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CH_ON  = 3'd1,
    S_CH_OFF = 3'd2,
    S_ALARM  = 3'd3,
    S_SNOOZE = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;        // seconds up-count in ALARM, down-count in SNOOZE
  logic [4:0]       r_beep_cnt;
  logic             r_pend_chime;
  logic [SNZ_W-1:0] r_snooze_cnt;
  logic             r_blink;
  logic             r_buzz;
  logic [3:0]       r_puncshow;
  logic [3:0]       r_alarmshow;
  logic [4:0]       r_prev_h;
  logic [7:0]       r_prev_m;

  logic [5:0] w_mbin;
  logic       w_time_changed;
  logic       w_alarm_match;
  logic       w_alarm_req;
  logic       w_chime_req;
  logic [4:0] w_beeps;
  logic       w_alarm_stop;

  // Request detection: edges of the time value against last cycle's copy
  always_comb begin
    w_mbin         = 6'(MDATA[7:4]) * 6'd10 + 6'(MDATA[3:0]);
    w_time_changed = ({HDATA, MDATA} != {r_prev_h, r_prev_m});
    w_alarm_match  = ({1'b0, HDATA} == HSET) && (w_mbin == MSET);
    w_alarm_req    = alarm_en && w_alarm_match && w_time_changed;
    w_chime_req    = chime_en && (MDATA == 8'h00) && (r_prev_m != 8'h00);
    w_beeps        = (HDATA == 5'd0) ? 5'd24 : HDATA;
    // Anything that ends the ring outright; exhausted snoozes behave as stop
    w_alarm_stop   = !alarm_en || stop || (snooze && (r_snooze_cnt >= c_MAX_SNZ));
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_beep_cnt   <= '0;
      r_pend_chime <= 1'b0;
      r_snooze_cnt <= '0;
      r_blink      <= 1'b0;
      r_buzz       <= 1'b0;
      r_puncshow   <= 4'h0;
      r_alarmshow  <= 4'h0;
      r_prev_h     <= '0;
      r_prev_m     <= '0;
    end else begin
      r_prev_h <= HDATA;
      r_prev_m <= MDATA;

      case (r_state)
        S_IDLE: begin
          if (w_alarm_req) begin
            // Alarm wins a same-cycle tie; the chime is parked
            r_state     <= S_ALARM;
            r_cnt       <= '0;
            r_blink     <= 1'b0;
            r_buzz      <= 1'b0;
            r_alarmshow <= 4'h0;
            r_puncshow  <= 4'h0;
            if (w_chime_req) r_pend_chime <= 1'b1;
          end else if (w_chime_req || r_pend_chime) begin
            r_state      <= S_CH_ON;
            r_beep_cnt   <= w_beeps;
            r_pend_chime <= 1'b0;
            r_buzz       <= 1'b1;
            r_puncshow   <= 4'hF;
          end
        end

        S_CH_ON: begin
          if (w_alarm_req) begin
            // Remaining beeps are dropped, not resumed
            r_state     <= S_ALARM;
            r_cnt       <= '0;
            r_blink     <= 1'b0;
            r_buzz      <= 1'b0;
            r_alarmshow <= 4'h0;
            r_puncshow  <= 4'h0;
            if (w_chime_req) r_pend_chime <= 1'b1;
          end else if (tick1hz) begin
            r_state    <= S_CH_OFF;
            r_beep_cnt <= r_beep_cnt - 5'd1;
            r_buzz     <= 1'b0;
            r_puncshow <= 4'h0;
          end
        end

        S_CH_OFF: begin
          if (w_alarm_req) begin
            r_state     <= S_ALARM;
            r_cnt       <= '0;
            r_blink     <= 1'b0;
            r_buzz      <= 1'b0;
            r_alarmshow <= 4'h0;
            r_puncshow  <= 4'h0;
            if (w_chime_req) r_pend_chime <= 1'b1;
          end else if (tick1hz) begin
            if (r_beep_cnt == 5'd0) begin
              r_state <= S_IDLE;
            end else begin
              r_state    <= S_CH_ON;
              r_buzz     <= 1'b1;
              r_puncshow <= 4'hF;
            end
          end
        end

        S_ALARM: begin
          if (w_chime_req) r_pend_chime <= 1'b1;
          if (w_alarm_stop) begin
            r_state      <= S_IDLE;
            r_snooze_cnt <= '0;
            r_cnt        <= '0;
            r_blink      <= 1'b0;
            r_buzz       <= 1'b0;
            r_alarmshow  <= 4'h0;
          end else if (snooze) begin
            r_state      <= S_SNOOZE;
            r_snooze_cnt <= r_snooze_cnt + c_SNZ_ONE;
            r_cnt        <= c_SNZ_LOAD;
            r_blink      <= 1'b0;
            r_buzz       <= 1'b0;
            r_alarmshow  <= 4'h0;
          end else begin
            if (tick8hz) begin
              r_blink     <= ~r_blink;
              r_buzz      <= ~r_blink;
              r_alarmshow <= {4{~r_blink}};
            end
            // Timeout is written last so it overrides a coincident blink toggle
            if (tick1hz) begin
              if (r_cnt == c_ALARM_LAST) begin
                r_state      <= S_IDLE;
                r_snooze_cnt <= '0;
                r_cnt        <= '0;
                r_blink      <= 1'b0;
                r_buzz       <= 1'b0;
                r_alarmshow  <= 4'h0;
              end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
              end
            end
          end
        end

        S_SNOOZE: begin
          // A pending chime waits here; it only plays from IDLE
          if (w_chime_req) r_pend_chime <= 1'b1;
          if (stop || !alarm_en) begin
            r_state      <= S_IDLE;
            r_snooze_cnt <= '0;
            r_cnt        <= '0;
          end else if (tick1hz) begin
            if (r_cnt <= c_CNT_ONE) begin
              r_state <= S_ALARM;
              r_cnt   <= '0;
              r_blink <= 1'b0;
            end else begin
              r_cnt <= r_cnt - c_CNT_ONE;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_buzz      <= 1'b0;
          r_puncshow  <= 4'h0;
          r_alarmshow <= 4'h0;
        end
      endcase
    end
  end

  assign buzz      = r_buzz;
  assign puncshow  = r_puncshow;
  assign alarmshow = r_alarmshow;
  assign busy      = (r_state != S_IDLE);
  assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_scheduler
// Purpose  : Directed self-checking bench for alarm_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_scheduler;

  logic       CP = 1'b0;
  logic       nCR = 1'b0;
  logic       tick1hz = 1'b0;
  logic       tick8hz = 1'b0;
  logic [4:0] HDATA = 5'd0;
  logic [7:0] MDATA = 8'h00;
  logic [5:0] HSET = 6'd0;
  logic [5:0] MSET = 6'd0;
  logic       alarm_en = 1'b0;
  logic       chime_en = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic       buzz;
  logic [3:0] puncshow;
  logic [3:0] alarmshow;
  logic       busy;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  alarm_scheduler dut (
    .CP        (CP),
    .nCR       (nCR),
    .tick1hz   (tick1hz),
    .tick8hz   (tick8hz),
    .HDATA     (HDATA),
    .MDATA     (MDATA),
    .HSET      (HSET),
    .MSET      (MSET),
    .alarm_en  (alarm_en),
    .chime_en  (chime_en),
    .snooze    (snooze),
    .stop      (stop),
    .buzz      (buzz),
    .puncshow  (puncshow),
    .alarmshow (alarmshow),
    .busy      (busy),
    .state_o   (state_o)
  );

  always #5 CP = ~CP;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic pulse_t1();
    tick1hz = 1'b1; step(); tick1hz = 1'b0;
  endtask

  task automatic pulse_t8();
    tick8hz = 1'b1; step(); tick8hz = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1; step(); snooze = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [7:0] m);
    HDATA = h; MDATA = m; step();
  endtask

  // Called with the DUT already in CH_ON; runs ticks until IDLE
  task automatic count_chime(input string tag, input int exp_beeps);
    int  beeps = 1;
    int  ticks = 0;
    int  bad = 0;
    bit  done = 1'b0;
    check_val({tag, " entry"}, 32'(state_o), 32'd1);
    for (int i = 0; i < 100 && !done; i++) begin
      pulse_t1();
      ticks++;
      if (state_o == 3'd1) begin
        beeps++;
        if (buzz !== 1'b1 || puncshow !== 4'hF) bad++;
      end else if (state_o == 3'd2) begin
        if (buzz !== 1'b0 || puncshow !== 4'h0) bad++;
      end else begin
        done = 1'b1;
      end
    end
    check_val({tag, " ended idle"}, 32'(state_o), 32'd0);
    check_val({tag, " beeps"}, 32'(beeps), 32'(exp_beeps));
    check_val({tag, " ticks"}, 32'(ticks), 32'(2 * exp_beeps));
    check_val({tag, " bad outputs"}, 32'(bad), 32'd0);
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(posedge CP);
    #1;
    check_val("rst state", 32'(state_o), 32'd0);
    check_val("rst buzz", 32'(buzz), 32'd0);
    check_val("rst busy", 32'(busy), 32'd0);
    check_val("rst punc", 32'(puncshow), 32'd0);
    check_val("rst ashow", 32'(alarmshow), 32'd0);
    nCR = 1'b1;
    step();

    // ---------------- chime 03:00 ----------------
    chime_en = 1'b1;
    set_time(5'd3, 8'h59);
    step();
    check_val("pre-chime idle", 32'(state_o), 32'd0);
    set_time(5'd3, 8'h00);
    check_val("chime3 buzz", 32'(buzz), 32'd1);
    check_val("chime3 punc", 32'(puncshow), 32'hF);
    check_val("chime3 busy", 32'(busy), 32'd1);
    step();
    check_val("chime3 hold on", 32'(state_o), 32'd1);
    count_chime("chime3", 3);

    // ---------------- chime 00:00 -> 24 beeps ----------------
    set_time(5'd23, 8'h59);
    set_time(5'd0, 8'h00);
    count_chime("chime0", 24);

    // ---------------- alarm 07:30 ----------------
    chime_en = 1'b0;
    alarm_en = 1'b1;
    HSET = 6'd7;
    MSET = 6'd30;
    set_time(5'd7, 8'h29);
    check_val("pre-alarm idle", 32'(state_o), 32'd0);
    set_time(5'd7, 8'h30);
    check_val("alarm entry", 32'(state_o), 32'd3);
    check_val("alarm entry buzz", 32'(buzz), 32'd0);
    pulse_t8();
    check_val("blink1 ashow", 32'(alarmshow), 32'hF);
    check_val("blink1 buzz", 32'(buzz), 32'd1);
    pulse_t8();
    check_val("blink2 ashow", 32'(alarmshow), 32'h0);
    check_val("blink2 buzz", 32'(buzz), 32'd0);
    for (int i = 0; i < 59; i++) pulse_t1();
    check_val("alarm 59s", 32'(state_o), 32'd3);
    pulse_t1();
    check_val("alarm 60s idle", 32'(state_o), 32'd0);
    repeat (5) step();
    check_val("no retrigger", 32'(state_o), 32'd0);

    // ---------------- snooze sequence ----------------
    set_time(5'd7, 8'h31);
    set_time(5'd7, 8'h30);
    check_val("alarm again", 32'(state_o), 32'd3);
    pulse_snooze();
    check_val("snooze1 state", 32'(state_o), 32'd4);
    check_val("snooze1 buzz", 32'(buzz), 32'd0);
    check_val("snooze1 busy", 32'(busy), 32'd1);
    for (int i = 0; i < 299; i++) pulse_t1();
    check_val("snooze1 299s", 32'(state_o), 32'd4);
    pulse_t1();
    check_val("snooze1 300s", 32'(state_o), 32'd3);
    check_val("re-ring ashow", 32'(alarmshow), 32'h0);
    for (int k = 2; k <= 3; k++) begin
      pulse_snooze();
      check_val("snooze n state", 32'(state_o), 32'd4);
      for (int i = 0; i < 300; i++) pulse_t1();
      check_val("snooze n back", 32'(state_o), 32'd3);
    end
    pulse_snooze();
    check_val("4th snooze stops", 32'(state_o), 32'd0);

    // ---------------- alarm_en drop during ALARM ----------------
    set_time(5'd7, 8'h31);
    set_time(5'd7, 8'h30);
    check_val("alarm for en drop", 32'(state_o), 32'd3);
    alarm_en = 1'b0;
    step();
    check_val("en drop idle", 32'(state_o), 32'd0);
    alarm_en = 1'b1;

    // ---------------- alarm + chime at 08:00 ----------------
    chime_en = 1'b1;
    HSET = 6'd8;
    MSET = 6'd0;
    set_time(5'd7, 8'h59);
    set_time(5'd8, 8'h00);
    check_val("tie alarm wins", 32'(state_o), 32'd3);
    pulse_stop();
    check_val("tie stop idle", 32'(state_o), 32'd0);
    step();
    count_chime("pend chime", 8);

    // ---------------- alarm during CH_OFF ----------------
    HSET = 6'd5;
    MSET = 6'd1;
    set_time(5'd4, 8'h59);
    set_time(5'd5, 8'h00);
    check_val("chime5 on", 32'(state_o), 32'd1);
    pulse_t1();
    check_val("chime5 off", 32'(state_o), 32'd2);
    set_time(5'd5, 8'h01);
    check_val("preempt alarm", 32'(state_o), 32'd3);
    check_val("preempt punc", 32'(puncshow), 32'h0);
    pulse_stop();
    check_val("preempt stop", 32'(state_o), 32'd0);
    repeat (3) step();
    check_val("chime not resumed", 32'(state_o), 32'd0);

    // ---------------- async reset mid-ALARM ----------------
    set_time(5'd5, 8'h02);
    set_time(5'd5, 8'h01);
    check_val("alarm for reset", 32'(state_o), 32'd3);
    pulse_t8();
    check_val("pre-reset buzz", 32'(buzz), 32'd1);
    set_time(5'd6, 8'h00);
    check_val("chime parked", 32'(state_o), 32'd3);
    @(negedge CP);
    nCR = 1'b0;
    #1;
    check_val("async state", 32'(state_o), 32'd0);
    check_val("async buzz", 32'(buzz), 32'd0);
    check_val("async ashow", 32'(alarmshow), 32'd0);
    check_val("async busy", 32'(busy), 32'd0);
    step();
    nCR = 1'b1;
    repeat (3) step();
    check_val("no residual pend", 32'(state_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
Single-clock controller that shares the board's one buzzer and LED indicator bank between two requesters: the hourly chime (top of the hour) and the user alarm (HSET:MSET match), with snooze/stop control. It sits between the timekeeping counters (HDATA/MDATA) and the output pins. It replaces free-running derived clocks with tick-enable pulses from the existing 1 Hz/8 Hz timer units, so all state is in the CP domain.

Parameters:
ALARM_SEC, 60, alarm ring duration in seconds per attempt
SNOOZE_MIN, 5, snooze delay in minutes
MAX_SNOOZE, 3, snoozes allowed before snooze acts as stop
CNT_W, 12, width of second/snooze countdown counter

Ports:
CP  input  1  system clock
nCR  input  1  asynchronous active-low reset
tick1hz  input  1  one-CP-cycle pulse, 1 Hz
tick8hz  input  1  one-CP-cycle pulse, 8 Hz
HDATA  input  5  current hour, binary 0..23
MDATA  input  8  current minute, BCD 00..59
HSET  input  6  alarm hour, binary
MSET  input  6  alarm minute, binary
alarm_en  input  1  alarm armed
chime_en  input  1  hourly chime enabled
snooze  input  1  one-cycle pulse (debounced upstream)
stop  input  1  one-cycle pulse (debounced upstream)
buzz  output  1  buzzer drive
puncshow  output  4  chime LEDs
alarmshow  output  4  alarm LEDs
busy  output  1  state != IDLE
state_o  output  3  current state encoding, for debug

Behaviour:
- Reset is asynchronous and active-low (nCR=0 acts immediately, no clock needed). During and after reset: state=IDLE, all counters 0, pend_chime=0, snooze_cnt=0, prev minute/hour regs=0, buzz=0, puncshow=0, alarmshow=0, busy=0.
- mbin = MDATA[7:4]*10 + MDATA[3:0], 6-bit. Previous {HDATA,MDATA} registered each CP.
- chime_req: 1-cycle pulse when MDATA changes to 8'h00 and chime_en=1. beeps = (HDATA==0) ? 24 : HDATA.
- alarm_req: 1-cycle pulse when {HDATA,mbin} changes to equal {HSET,MSET} and alarm_en=1. Fires once per match minute, not while static.
- Request detected in cycle N; state change visible in cycle N+1.
- States: IDLE=0, CH_ON=1, CH_OFF=2, ALARM=3, SNOOZE=4.
- IDLE: alarm_req -> ALARM (sec_cnt=0). Else chime_req or pend_chime -> CH_ON (beep_cnt=beeps, pend_chime cleared).
- CH_ON: buzz=1, puncshow=4'hF. On tick1hz -> CH_OFF, beep_cnt-1.
- CH_OFF: outputs 0. On tick1hz: beep_cnt==0 -> IDLE, else CH_ON.
- Alarm preempts chime: alarm_req in CH_ON/CH_OFF -> ALARM same cycle; the remaining chime is dropped (not resumed).
- ALARM: blink toggles on tick8hz (reset to 0 on entry); buzz=blink, alarmshow={4{blink}}. sec_cnt increments on tick1hz. sec_cnt==ALARM_SEC-1 with tick1hz -> IDLE, snooze_cnt=0. stop -> IDLE, snooze_cnt=0. snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1, cnt=SNOOZE_MIN*60. snooze with snooze_cnt==MAX_SNOOZE treated as stop.
- SNOOZE: outputs 0, busy=1. Decrement cnt on tick1hz; at 0 -> ALARM (sec_cnt=0). stop -> IDLE, snooze_cnt=0. alarm_en=0 -> IDLE.
- chime_req while in ALARM or SNOOZE sets pend_chime (one deep; a second request is absorbed). Served from IDLE after the alarm sequence ends. In SNOOZE a pending chime waits; it does not play.
- Same-cycle alarm_req and chime_req in IDLE: ALARM wins, pend_chime=1.
- stop in IDLE/CH_* ignored; snooze outside ALARM ignored.
- tick coincident with stop/snooze: stop/snooze take priority over the timeout.
- alarm_en deasserted during ALARM -> IDLE next cycle.

Test Plan:
- Reset mid-ALARM (nCR low between edges) -> all outputs 0 immediately, state_o=0, no residual pend_chime after release.
- HDATA 3, MDATA 59->00, chime_en=1 -> 3 beeps of 1 s on/1 s off, puncshow=F while on, IDLE after 6 tick1hz; HDATA=0 -> 24 beeps.
- HSET=7, MSET=30, clock reaches 07:30 -> ALARM, alarmshow toggles every tick8hz, returns to IDLE after 60 tick1hz; staying at 07:30 does not re-trigger.
- Alarm ring, snooze pulse -> SNOOZE for 300 tick1hz, then ALARM again; 4th snooze acts as stop (snooze_cnt 3 -> IDLE).
- Chime at 08:00 while alarm at 08:00 -> ALARM first, pend_chime=1; stop -> IDLE, then 8-beep chime starts the next cycle.
- Alarm_req during CH_OFF of a 5-beep chime -> ALARM next cycle; chime not resumed after stop.
